// File: rtl/systolic_feeder.sv
// systolic_feeder: transmit side of the PE a/b interface.
//   Buffers one NxN operand pair (A, B) loaded column-of-A / row-of-B per beat,
//   then drives diagonally skewed, zero-padded streams into the left (a) and
//   top (b) edges of an NxN PE array for 2N-1 cycles. No arithmetic.
//
// Optional feature macro: FEEDER_DBUF_EN
//   undefined : single bank, s_ready only in LOAD, at least one LOAD cycle
//               between feeds.
//   defined   : two banks; the idle bank loads while the other is fed, and a
//               full idle bank starts feeding back-to-back after feed_done.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active low
//   s_valid      load beat valid
//   s_ready      feeder accepts a beat this cycle
//   s_a_col      beat k, lane i = A[i][k]
//   s_b_row      beat k, lane j = B[k][j]
//   a_out        lane i -> a_in of PE row i, column 0
//   b_out        lane j -> b_in of PE column j, row 0
//   feed_active  high on every feed cycle t = 0..2N-2
//   feed_first   pulse on t = 0
//   feed_done    pulse on t = 2N-2
//
// Lane x of every bus occupies bits [x*WIDTH +: WIDTH].

// One output lane: picks element k = t - LANE of its row (A) / column (B)
// when that index is in range, otherwise drives zero padding.
module systolic_feeder_lane #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int LANE  = 0,
  parameter int TW    = 3
) (
  input  logic                        i_en,
  input  logic [TW-1:0]               i_t,
  input  logic [N-1:0][WIDTH-1:0]     i_elems,
  output logic [WIDTH-1:0]            o_sel
);
  // At most one k matches, so an OR chain acts as a one-hot mux.
  for (genvar k = 0; k < N; k++) begin : g_k
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_or;
    assign w_term = (i_en && (i_t == TW'(k + LANE))) ? i_elems[k] : '0;
    if (k == 0) begin : g_first
      assign w_or = w_term;
    end else begin : g_rest
      assign w_or = g_k[k-1].w_or | w_term;
    end
  end
  assign o_sel = g_k[N-1].w_or;
endmodule

module systolic_feeder #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [N*WIDTH-1:0]   s_a_col,
  input  logic [N*WIDTH-1:0]   s_b_row,
  output logic [N*WIDTH-1:0]   a_out,
  output logic [N*WIDTH-1:0]   b_out,
  output logic                 feed_active,
  output logic                 feed_first,
  output logic                 feed_done
);
  localparam int TW = $clog2(2 * N);
  localparam int CW = $clog2(N + 1);
`ifdef FEEDER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic [TW-1:0] T_LAST   = TW'(2 * N - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  typedef enum logic {S_LOAD, S_FEED} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_t, w_t_nxt;
  logic [CW-1:0]   r_ld_cnt, w_ld_cnt_nxt;
  logic            r_ld_bank, w_ld_bank_nxt;
  logic            r_fd_bank, w_fd_bank_nxt;
  logic            w_acc, w_full, w_feed_nxt;
  logic            r_first, r_done;

  logic [N-1:0][WIDTH-1:0] w_a_beat, w_b_beat;
  // r_a[bank][i][k] = A[i][k]; r_b[bank][j][k] = B[k][j] (stored transposed
  // so both edges share the same lane selector).
  logic [NB-1:0][N-1:0][N-1:0][WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
  logic [N-1:0][N-1:0][WIDTH-1:0]         w_a_sel, w_b_sel;
  logic [N-1:0][WIDTH-1:0]                w_a_lane, w_b_lane, r_a_out, r_b_out;

  assign w_a_beat = s_a_col;
  assign w_b_beat = s_b_row;

  // State / counters next-state logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_t_nxt       = r_t;
    w_ld_cnt_nxt  = r_ld_cnt;
    w_ld_bank_nxt = r_ld_bank;
    w_fd_bank_nxt = r_fd_bank;
    s_ready       = 1'b0;
    w_full        = 1'b0;

    case (r_state)
      S_LOAD:  s_ready = 1'b1;
`ifdef FEEDER_DBUF_EN
      S_FEED:  s_ready = (r_ld_cnt != CNT_FULL);
`endif
      default: s_ready = 1'b0;
    endcase

    w_acc = s_valid && s_ready;
    if (w_acc) w_ld_cnt_nxt = r_ld_cnt + CW'(1);

    // Loading bank holds all N beats once this edge completes; a beat landing
    // on the feed_done edge counts, so it starts without a LOAD bubble.
    w_full = w_acc ? (r_ld_cnt == CNT_LAST) : (r_ld_cnt == CNT_FULL);

    case (r_state)
      S_LOAD: begin
        if (w_full) begin
          w_state_nxt   = S_FEED;
          w_t_nxt       = '0;
          w_fd_bank_nxt = r_ld_bank;
          w_ld_cnt_nxt  = '0;
`ifdef FEEDER_DBUF_EN
          w_ld_bank_nxt = ~r_ld_bank;
`endif
        end
      end
      S_FEED: begin
        if (r_t != T_LAST) begin
          w_t_nxt = r_t + TW'(1);
        end else if (w_full) begin
          w_t_nxt       = '0;
          w_fd_bank_nxt = r_ld_bank;
          w_ld_cnt_nxt  = '0;
`ifdef FEEDER_DBUF_EN
          w_ld_bank_nxt = ~r_ld_bank;
`endif
        end else begin
          w_state_nxt = S_LOAD;
          w_t_nxt     = '0;
        end
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  assign w_feed_nxt = (w_state_nxt == S_FEED);

  // Bank write: beat k of the loading bank lands in slot k.
  for (genvar bk = 0; bk < NB; bk++) begin : g_bank
    for (genvar x = 0; x < N; x++) begin : g_lane
      for (genvar k = 0; k < N; k++) begin : g_slot
        logic w_we;
        assign w_we = w_acc && (r_ld_bank == 1'(bk)) && (r_ld_cnt == CW'(k));
        assign w_a_nxt[bk][x][k] = w_we ? w_a_beat[x] : r_a[bk][x][k];
        assign w_b_nxt[bk][x][k] = w_we ? w_b_beat[x] : r_b[bk][x][k];
      end
    end
  end

  // Outputs are registered, so the selectors look at next-cycle bank
  // contents; this forwards the N-th beat into the t = 0 values.
  assign w_a_sel = w_a_nxt[w_fd_bank_nxt];
  assign w_b_sel = w_b_nxt[w_fd_bank_nxt];

  for (genvar x = 0; x < N; x++) begin : g_out
    systolic_feeder_lane #(.WIDTH(WIDTH), .N(N), .LANE(x), .TW(TW)) u_a (
      .i_en(w_feed_nxt), .i_t(w_t_nxt), .i_elems(w_a_sel[x]), .o_sel(w_a_lane[x])
    );
    systolic_feeder_lane #(.WIDTH(WIDTH), .N(N), .LANE(x), .TW(TW)) u_b (
      .i_en(w_feed_nxt), .i_t(w_t_nxt), .i_elems(w_b_sel[x]), .o_sel(w_b_lane[x])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_LOAD;
      r_t       <= '0;
      r_ld_cnt  <= '0;
      r_ld_bank <= 1'b0;
      r_fd_bank <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_a_out   <= '0;
      r_b_out   <= '0;
      r_first   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_t       <= w_t_nxt;
      r_ld_cnt  <= w_ld_cnt_nxt;
      r_ld_bank <= w_ld_bank_nxt;
      r_fd_bank <= w_fd_bank_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_a_out   <= w_a_lane;
      r_b_out   <= w_b_lane;
      r_first   <= w_feed_nxt && (w_t_nxt == '0);
      r_done    <= w_feed_nxt && (w_t_nxt == T_LAST);
    end
  end

  assign a_out       = r_a_out;
  assign b_out       = r_b_out;
  assign feed_active = (r_state == S_FEED);
  assign feed_first  = r_first;
  assign feed_done   = r_done;
endmodule
